// File: rtl/delay_update_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_update_sched_pkg
// Purpose  : Register offsets, FSM states and readback layout shared by the
//            delay update scheduler and the delay NoC block.
// Revision : 1.0 - initial release
// ============================================================================
package delay_update_sched_pkg;

  // Settings register offsets relative to SR_BASE
  localparam int SR_DELAY_I     = 0;
  localparam int SR_DELAY_Q     = 1;
  localparam int SR_ENABLE_DIFF = 2;
  localparam int SR_STEP        = 3;
  localparam int SR_COMMIT      = 4;
  localparam int SR_CLEAR_ERR   = 5;

  // Sticky error bit positions inside err
  localparam int ERR_DIFF_BIT   = 0;
  localparam int ERR_RANGE_BIT  = 1;

  // rb_status field positions
  localparam int RB_LEN_I_LSB   = 0;
  localparam int RB_LEN_Q_LSB   = 24;
  localparam int RB_BUSY_BIT    = 61;
  localparam int RB_ERR_LSB     = 62;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/delay_update_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_update_sched_if
// Purpose  : Settings bus, monitored stream handshake and delay outputs of
//            the delay update scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface delay_update_sched_if #(
  parameter int MAX_DELAY_LOG2 = 16
) ();
  logic                      set_stb;
  logic [7:0]                set_addr;
  logic [31:0]               set_data;
  logic                      s_tvalid;
  logic                      s_tready;
  logic                      s_tlast;
  logic [MAX_DELAY_LOG2-1:0] len_i;
  logic [MAX_DELAY_LOG2-1:0] len_q;
  logic                      busy;
  logic                      done;
  logic [1:0]                err;
  logic [63:0]               rb_status;

  // Settings/stream source side
  modport master (
    output set_stb, set_addr, set_data, s_tvalid, s_tready, s_tlast,
    input  len_i, len_q, busy, done, err, rb_status
  );

  // Scheduler side
  modport slave (
    input  set_stb, set_addr, set_data, s_tvalid, s_tready, s_tlast,
    output len_i, len_q, busy, done, err, rb_status
  );
endinterface
`default_nettype wire

// File: rtl/delay_update_sched_stepper.sv
`default_nettype none
// ============================================================================
// Module   : delay_update_sched_stepper
// Purpose  : One channel's applied delay. On advance, moves len toward the
//            target by min(step, distance); step 0 jumps the full distance.
// Revision : 1.0 - initial release
// ============================================================================
module delay_update_sched_stepper #(
  parameter int MAX_DELAY_LOG2 = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      adv_i,
  input  logic [MAX_DELAY_LOG2-1:0] target_i,
  input  logic [MAX_DELAY_LOG2-1:0] step_i,
  output logic [MAX_DELAY_LOG2-1:0] len_o,
  output logic                      next_at_target_o
);
  logic [MAX_DELAY_LOG2-1:0] len_q;
  logic [MAX_DELAY_LOG2-1:0] len_d;
  logic [MAX_DELAY_LOG2-1:0] w_stepped;
  logic [MAX_DELAY_LOG2-1:0] w_dist;
  logic [MAX_DELAY_LOG2-1:0] w_move;
  logic                      w_up;

  // Clamped step toward the target; the distance is taken in the direction
  // of travel so it can never underflow.
  always_comb begin
    w_up      = (target_i >= len_q);
    w_dist    = w_up ? (target_i - len_q) : (len_q - target_i);
    w_move    = ((step_i == '0) || (step_i > w_dist)) ? w_dist : step_i;
    w_stepped = w_up ? (len_q + w_move) : (len_q - w_move);
    len_d     = adv_i ? w_stepped : len_q;
  end

  // Applied delay register
  always_ff @(posedge clk) begin
    if (!reset_n) len_q <= '0;
    else          len_q <= len_d;
  end

  assign len_o            = len_q;
  assign next_at_target_o = (w_stepped == target_i);
endmodule
`default_nettype wire

// File: rtl/delay_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : delay_update_sched
// Purpose  : Settings-bus controller that stages I/Q delay targets, checks
//            them on COMMIT and ramps the delay lines on stream boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module delay_update_sched #(
  parameter int MAX_DELAY_LOG2      = 16,
  parameter int MAX_DIFF_DELAY_LOG2 = 10,
  parameter int SR_BASE             = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  delay_update_sched_if.slave   bus
);
  import delay_update_sched_pkg::*;

  localparam int W = MAX_DELAY_LOG2;
  localparam logic [7:0] ADDR_DELAY_I = 8'(SR_BASE + SR_DELAY_I);
  localparam logic [7:0] ADDR_DELAY_Q = 8'(SR_BASE + SR_DELAY_Q);
  localparam logic [7:0] ADDR_EN_DIFF = 8'(SR_BASE + SR_ENABLE_DIFF);
  localparam logic [7:0] ADDR_STEP    = 8'(SR_BASE + SR_STEP);
  localparam logic [7:0] ADDR_COMMIT  = 8'(SR_BASE + SR_COMMIT);
  localparam logic [7:0] ADDR_CLR_ERR = 8'(SR_BASE + SR_CLEAR_ERR);
  localparam logic [W:0] DIFF_LIMIT   = (W+1)'(1) << MAX_DIFF_DELAY_LOG2;

  logic [31:0]  stg_i_q, stg_q_q;
  logic         stg_diff_q;
  logic [W-1:0] stg_step_q;
  logic [W-1:0] tgt_i_q, tgt_q_q, step_q;
  logic         mode_q, done_q;
  logic [1:0]   err_q, err_d;
  state_t       state_q;

  logic         w_commit, w_clear, w_range, w_diff_bad, w_accept;
  logic         w_boundary, w_adv, w_at_i, w_at_q;
  logic [31:0]  w_tq32;
  logic [W-1:0] w_ti, w_tq, w_len_i, w_len_q;
  logic [W:0]   w_abs;

  assign w_commit = bus.set_stb && (bus.set_addr == ADDR_COMMIT);
  assign w_clear  = bus.set_stb && (bus.set_addr == ADDR_CLR_ERR);

  // Staging registers: settings writes land here and take no effect until COMMIT
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stg_i_q    <= '0;
      stg_q_q    <= '0;
      stg_diff_q <= 1'b0;
      stg_step_q <= '0;
    end else if (bus.set_stb) begin
      case (bus.set_addr)
        ADDR_DELAY_I: stg_i_q    <= bus.set_data;
        ADDR_DELAY_Q: stg_q_q    <= bus.set_data;
        ADDR_EN_DIFF: stg_diff_q <= bus.set_data[0];
        ADDR_STEP:    stg_step_q <= bus.set_data[W-1:0];
        default:      ;
      endcase
    end
  end

  // COMMIT checks: range on the full 32-bit staged words, then I/Q spread
  always_comb begin
    w_tq32     = stg_diff_q ? stg_q_q : stg_i_q;
    w_range    = (|stg_i_q[31:W]) || (|w_tq32[31:W]);
    w_ti       = stg_i_q[W-1:0];
    w_tq       = w_tq32[W-1:0];
    w_abs      = (w_ti >= w_tq) ? ({1'b0, w_ti} - {1'b0, w_tq})
                                : ({1'b0, w_tq} - {1'b0, w_ti});
    w_diff_bad = !w_range && (w_abs > DIFF_LIMIT);
    w_accept   = w_commit && !w_range && !w_diff_bad;
  end

  // Sticky errors; a rejecting COMMIT overrides a same-cycle clear
  always_comb begin
    err_d = err_q;
    if (w_clear) err_d = '0;
    if (w_commit && w_range)    err_d[ERR_RANGE_BIT] = 1'b1;
    if (w_commit && w_diff_bad) err_d[ERR_DIFF_BIT]  = 1'b1;
  end

  assign w_boundary = bus.s_tvalid && bus.s_tready && (mode_q || bus.s_tlast);
  assign w_adv      = (state_q == ST_RAMP) && w_boundary;

  // Channel steppers always move toward the targets held before any
  // same-cycle COMMIT, so a retarget only affects the following boundary.
  delay_update_sched_stepper #(.MAX_DELAY_LOG2(W)) u_step_i (
    .clk(clk), .reset_n(reset_n), .adv_i(w_adv), .target_i(tgt_i_q),
    .step_i(step_q), .len_o(w_len_i), .next_at_target_o(w_at_i)
  );

  delay_update_sched_stepper #(.MAX_DELAY_LOG2(W)) u_step_q (
    .clk(clk), .reset_n(reset_n), .adv_i(w_adv), .target_i(tgt_q_q),
    .step_i(step_q), .len_o(w_len_q), .next_at_target_o(w_at_q)
  );

  // Update FSM: latch accepted targets, finish when both channels land
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tgt_i_q <= '0;
      tgt_q_q <= '0;
      step_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      err_q  <= err_d;
      done_q <= 1'b0;
      if (w_accept) begin
        tgt_i_q <= w_ti;
        tgt_q_q <= w_tq;
        step_q  <= stg_step_q;
        mode_q  <= bus.set_data[0];
      end
      case (state_q)
        ST_IDLE: if (w_accept) state_q <= ST_RAMP;
        ST_RAMP: if (!w_accept && w_adv && w_at_i && w_at_q) begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.len_i     = w_len_i;
  assign bus.len_q     = w_len_q;
  assign bus.busy      = (state_q == ST_RAMP);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rb_status = {err_q, (state_q == ST_RAMP), 13'd0,
                          24'(w_len_q), 24'(w_len_i)};
endmodule
`default_nettype wire

// File: tb/tb_delay_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_update_sched
// Purpose  : Directed bench for delay_update_sched with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_update_sched;
  localparam int BASE = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_en = 1'b0;

  delay_update_sched_if #(.MAX_DELAY_LOG2(16)) bus ();

  delay_update_sched #(
    .MAX_DELAY_LOG2(16), .MAX_DIFF_DELAY_LOG2(10), .SR_BASE(BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // ---------------- reference model ----------------
  longint m_si, m_sq, m_sstep;
  bit     m_en, m_mode, m_busy, m_done;
  int     m_li, m_lq, m_ti, m_tq, m_st;
  int     m_err;

  function automatic int move_to(int cur, int tgt, int st);
    int d, mv;
    d  = (tgt > cur) ? tgt - cur : cur - tgt;
    mv = (st == 0 || st > d) ? d : st;
    return (tgt >= cur) ? cur + mv : cur - mv;
  endfunction

  always @(posedge clk) begin
    longint tq, ad;
    bit bnd, com, clr, rng, dif, acc;
    if (!reset_n) begin
      m_si = 0; m_sq = 0; m_sstep = 0; m_en = 0; m_mode = 0;
      m_busy = 0; m_done = 0; m_li = 0; m_lq = 0; m_ti = 0; m_tq = 0;
      m_st = 0; m_err = 0;
    end else begin
      bnd = bus.s_tvalid && bus.s_tready && (m_mode || bus.s_tlast);
      com = bus.set_stb && bus.set_addr == BASE + 4;
      clr = bus.set_stb && bus.set_addr == BASE + 5;
      tq  = m_en ? m_sq : m_si;
      rng = (m_si >= 65536) || (tq >= 65536);
      ad  = (m_si > tq) ? m_si - tq : tq - m_si;
      dif = !rng && ad > 1024;
      acc = com && !rng && !dif;
      m_done = 0;
      if (m_busy && bnd) begin
        m_li = move_to(m_li, m_ti, m_st);
        m_lq = move_to(m_lq, m_tq, m_st);
        if (!acc && m_li == m_ti && m_lq == m_tq) begin
          m_done = 1; m_busy = 0;
        end
      end
      if (clr) m_err = 0;
      if (com && rng) m_err = m_err | 2;
      if (com && dif) m_err = m_err | 1;
      if (acc) begin
        m_ti = int'(m_si); m_tq = int'(tq); m_st = int'(m_sstep);
        m_mode = bus.set_data[0]; m_busy = 1;
      end
      if (bus.set_stb) begin
        if (bus.set_addr == BASE + 0) m_si = bus.set_data;
        if (bus.set_addr == BASE + 1) m_sq = bus.set_data;
        if (bus.set_addr == BASE + 2) m_en = bus.set_data[0];
        if (bus.set_addr == BASE + 3) m_sstep = bus.set_data[15:0];
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("len_i", 64'(bus.len_i), 64'(m_li));
      check("len_q", 64'(bus.len_q), 64'(m_lq));
      check("busy",  64'(bus.busy),  64'(m_busy));
      check("done",  64'(bus.done),  64'(m_done));
      check("err",   64'(bus.err),   64'(m_err));
      check("rb_status", bus.rb_status,
            {m_err[1:0], m_busy, 13'd0, 24'(m_lq), 24'(m_li)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int off, input logic [31:0] data);
    bus.set_stb = 1'b1; bus.set_addr = 8'(BASE + off); bus.set_data = data;
    tick();
    bus.set_stb = 1'b0; bus.set_addr = '0; bus.set_data = '0;
  endtask

  task automatic beat(input logic last);
    bus.s_tvalid = 1'b1; bus.s_tready = 1'b1; bus.s_tlast = last;
    tick();
    bus.s_tvalid = 1'b0; bus.s_tready = 1'b0; bus.s_tlast = 1'b0;
  endtask

  task automatic ramp_until_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      beat(1'b0);
      seen = bus.done;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic basic_jump();
    wr(0, 100); wr(2, 0); wr(3, 0); wr(4, 0);
    check("t1_busy_after_commit", 64'(bus.busy), 64'd1);
    beat(1'b0);
    check("t1_no_tlast_no_move", 64'(bus.len_i), 64'd0);
    beat(1'b1);
    check("t1_len_i", 64'(bus.len_i), 64'd100);
    check("t1_len_q", 64'(bus.len_q), 64'd100);
    check("t1_done", 64'(bus.done), 64'd1);
    check("t1_busy", 64'(bus.busy), 64'd0);
    tick();
    check("t1_done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  initial begin
    int d;
    bus.set_stb = 0; bus.set_addr = '0; bus.set_data = '0;
    bus.s_tvalid = 0; bus.s_tready = 0; bus.s_tlast = 0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_len_i", 64'(bus.len_i), 64'd0);
    check("rst_rb", bus.rb_status, 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: single-step jump on tlast
    basic_jump();

    // 2: stepped ramp, mode 1, with a stall
    wr(0, 0); wr(4, 1); beat(1'b0);
    check("t2_back_to_zero", 64'(bus.len_i), 64'd0);
    wr(3, 30); wr(0, 100); wr(4, 1);
    beat(1'b0); check("t2_30", 64'(bus.len_i), 64'd30);
    beat(1'b0); check("t2_60", 64'(bus.len_i), 64'd60);
    bus.s_tvalid = 1; bus.s_tready = 0; tick(); tick();
    bus.s_tvalid = 0;
    check("t2_stall", 64'(bus.len_i), 64'd60);
    beat(1'b0); check("t2_90", 64'(bus.len_i), 64'd90);
    beat(1'b0); check("t2_100", 64'(bus.len_i), 64'd100);
    check("t2_done", 64'(bus.done), 64'd1);

    // 3: differential limit
    wr(2, 1); wr(0, 2000); wr(1, 900); wr(4, 0);
    check("t3_diff_err", 64'(bus.err), 64'd1);
    check("t3_not_busy", 64'(bus.busy), 64'd0);
    check("t3_len_kept", 64'(bus.len_i), 64'd100);
    wr(5, 0);
    check("t3_cleared", 64'(bus.err), 64'd0);

    // 4: range error, then wide ramp with spread bound
    wr(0, 32'h0001_0000); wr(4, 0);
    check("t4_range_err", 64'(bus.err), 64'd2);
    wr(5, 0);
    wr(0, 1000); wr(1, 10); wr(3, 100); wr(4, 1);
    for (int k = 0; k < 20 && bus.busy; k++) begin
      beat(1'b0);
      d = int'(bus.len_i) - int'(bus.len_q);
      if (d < 0) d = -d;
      check("t4_spread_ok", 64'(d <= 990), 64'd1);
    end
    check("t4_final_i", 64'(bus.len_i), 64'd1000);
    check("t4_final_q", 64'(bus.len_q), 64'd10);

    // 5: retarget mid-ramp and COMMIT coinciding with a boundary
    wr(2, 0); wr(3, 0); wr(0, 100); wr(4, 1); beat(1'b0);
    wr(3, 40); wr(0, 0); wr(4, 1); beat(1'b0);
    check("t5_60", 64'(bus.len_i), 64'd60);
    wr(0, 50); wr(4, 1); beat(1'b0);
    check("t5_retarget_50", 64'(bus.len_i), 64'd50);
    check("t5_retarget_done", 64'(bus.done), 64'd1);
    wr(0, 0); wr(4, 1); beat(1'b0);
    check("t5_10", 64'(bus.len_i), 64'd10);
    wr(0, 200);
    bus.set_stb = 1; bus.set_addr = 8'(BASE + 4); bus.set_data = 1;
    bus.s_tvalid = 1; bus.s_tready = 1;
    tick();
    bus.set_stb = 0; bus.set_addr = '0; bus.set_data = '0;
    bus.s_tvalid = 0; bus.s_tready = 0;
    check("t5_old_target_first", 64'(bus.len_i), 64'd0);
    check("t5_still_busy", 64'(bus.busy), 64'd1);
    beat(1'b0);
    check("t5_new_target_40", 64'(bus.len_i), 64'd40);
    ramp_until_done("t5_reach_200", 10);
    check("t5_200", 64'(bus.len_i), 64'd200);
    wr(4, 1);
    check("t5_equal_busy", 64'(bus.busy), 64'd1);
    beat(1'b0);
    check("t5_equal_done", 64'(bus.done), 64'd1);

    // 6: reset mid-ramp
    wr(3, 10); wr(0, 0); wr(4, 1); beat(1'b0);
    check("t6_190", 64'(bus.len_i), 64'd190);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("t6_rst_len", 64'(bus.len_i), 64'd0);
    check("t6_rst_busy", 64'(bus.busy), 64'd0);
    check("t6_rst_rb", bus.rb_status, 64'd0);
    basic_jump();

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
